// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter sharing one fixed-point (S10.21) multiplier.
// Rev 1.0 -- initial release.
`default_nettype none

module multiplier (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [63:0] o_p
);
   assign o_p = {32'b0, i_a} * {32'b0, i_b};
endmodule

module mul_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*32-1:0] req_a,
   input  logic [NUM_REQ*32-1:0] req_b,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   resp_valid,
   input  logic [NUM_REQ-1:0]   resp_ready,
   output logic [31:0]          resp_result,
   output logic                 resp_ovf,
   output logic                 busy
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t             r_state;
   logic [IW-1:0]      r_rr_ptr;
   logic [IW-1:0]      r_id;
   logic [31:0]        r_op_a;
   logic [31:0]        r_op_b;
   logic [NUM_REQ-1:0] r_resp_valid;
   logic [31:0]        r_result;
   logic               r_ovf;
   logic               r_busy;

   logic [63:0]        w_prod;
   logic [IW-1:0]      w_gnt_id;
   logic               w_found;
   logic               w_grant;
   logic [NUM_REQ-1:0] w_id_oh;

   multiplier u_mul (
      .i_a (r_op_a),
      .i_b (r_op_b),
      .o_p (w_prod)
   );

   // First valid requester searching upward from r_rr_ptr with wrap.
   always_comb begin
      logic [IW-1:0] v_idx;
      v_idx    = '0;
      w_gnt_id = '0;
      w_found  = 1'b0;
      for (int off = 0; off < NUM_REQ; off++) begin
         v_idx = IW'((int'(r_rr_ptr) + off) % NUM_REQ);
         if (!w_found && req_valid[v_idx]) begin
            w_found  = 1'b1;
            w_gnt_id = v_idx;
         end
      end
   end

   assign w_grant = (r_state == ST_IDLE) && w_found && !rst;
   assign w_id_oh = NUM_REQ'(1) << r_id;

   always_comb begin
      req_ready = '0;
      if (w_grant) begin
         req_ready[w_gnt_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rr_ptr     <= '0;
         r_id         <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_resp_valid <= '0;
         r_result     <= '0;
         r_ovf        <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_op_a   <= req_a[int'(w_gnt_id)*32 +: 32];
                  r_op_b   <= req_b[int'(w_gnt_id)*32 +: 32];
                  r_id     <= w_gnt_id;
                  r_rr_ptr <= (w_gnt_id == IW'(NUM_REQ-1)) ? '0 : w_gnt_id + 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= ST_MUL;
               end
            end
            ST_MUL: begin
               r_result     <= w_prod[52:21];
               r_ovf        <= |w_prod[63:53];
               r_resp_valid <= w_id_oh;
               r_state      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready[r_id]) begin
                  r_resp_valid <= '0;
                  r_busy       <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign resp_valid  = r_resp_valid;
   assign resp_result = r_result;
   assign resp_ovf    = r_ovf;
   assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: directed vector table plus hand-written multi-cycle sequences.
// Rev 1.0 -- initial release.
`default_nettype none

module tb_mul_arbiter;
   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [3:0]   req_valid = '0;
   logic [127:0] req_a = '0;
   logic [127:0] req_b = '0;
   logic [3:0]   req_ready;
   logic [3:0]   resp_valid;
   logic [3:0]   resp_ready = '0;
   logic [31:0]  resp_result;
   logic         resp_ovf;
   logic         busy;

   int n_vec  = 0;
   int n_fail = 0;

   mul_arbiter #(.NUM_REQ(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_result (resp_result),
      .resp_ovf    (resp_ovf),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          req;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs[NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'h0);
      chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
      chk({tag, "_result"}, 64'(resp_result), 64'h0);
      chk({tag, "_ovf"}, 64'(resp_ovf), 64'h0);
      chk({tag, "_busy"}, 64'(busy), 64'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      #1;
      chk_all_zero("reset");
      rst = 1'b0;
   endtask

   initial begin
      int exp_order[6];
      int exp_tail[2];
      int g_cnt;
      int last_cyc;

      vecs[0] = '{0, 32'h0020_0000, 32'h0060_0000, 32'h0060_0000, 1'b0}; // 1.0 * 3.0
      vecs[1] = '{1, 32'h0010_0000, 32'h0010_0000, 32'h0008_0000, 1'b0}; // 0.5 * 0.5
      vecs[2] = '{1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0}; // lsb truncated away
      vecs[3] = '{2, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1}; // 512 * 512
      vecs[4] = '{3, 32'hFFFF_FFFF, 32'h0020_0000, 32'hFFFF_FFFF, 1'b0}; // full window, no ovf
      vecs[5] = '{0, 32'h0030_0000, 32'h0050_0000, 32'h0078_0000, 1'b0}; // 1.5 * 2.5
      vecs[6] = '{2, 32'h0040_0000, 32'h8000_0000, 32'h0000_0000, 1'b1}; // product bit 53 only

      do_reset();
      resp_ready = 4'hF;

      for (int i = 0; i < NV; i++) begin
         req_valid = '0;
         req_valid[vecs[i].req] = 1'b1;
         req_a[vecs[i].req*32 +: 32] = vecs[i].a;
         req_b[vecs[i].req*32 +: 32] = vecs[i].b;
         #1;
         chk("grant", 64'(req_ready), 64'(1 << vecs[i].req));
         chk("idle_busy", 64'(busy), 64'h0);
         chk("idle_resp_valid", 64'(resp_valid), 64'h0);
         tick();
         req_valid = '0;
         #1;
         chk("mul_busy", 64'(busy), 64'h1);
         chk("mul_resp_valid", 64'(resp_valid), 64'h0);
         chk("mul_req_ready", 64'(req_ready), 64'h0);
         tick();
         #1;
         chk("resp_valid", 64'(resp_valid), 64'(1 << vecs[i].req));
         chk("result", 64'(resp_result), 64'(vecs[i].res));
         chk("ovf", 64'(resp_ovf), 64'(vecs[i].ovf));
         tick();
         #1;
         chk("ret_busy", 64'(busy), 64'h0);
         chk("ret_resp_valid", 64'(resp_valid), 64'h0);
      end

      // Round-robin with all requesters valid, then only 1 and 3 from rr_ptr=2.
      do_reset();
      resp_ready = 4'hF;
      req_valid  = 4'hF;
      exp_order  = '{0, 1, 2, 3, 0, 1};
      g_cnt      = 0;
      last_cyc   = -1;
      for (int cyc = 0; cyc < 40 && g_cnt < 6; cyc++) begin
         #1;
         if (req_ready != 4'h0) begin
            chk("rr_order", 64'(req_ready), 64'(1 << exp_order[g_cnt]));
            if (g_cnt > 0) chk("rr_spacing", 64'(cyc - last_cyc), 64'd3);
            last_cyc = cyc;
            g_cnt++;
         end
         tick();
      end
      chk("rr_count", 64'(g_cnt), 64'd6);
      req_valid = 4'b1010;
      exp_tail  = '{3, 1};
      g_cnt     = 0;
      for (int cyc = 0; cyc < 20 && g_cnt < 2; cyc++) begin
         #1;
         if (req_ready != 4'h0) begin
            chk("rr_tail_order", 64'(req_ready), 64'(1 << exp_tail[g_cnt]));
            g_cnt++;
         end
         tick();
      end
      chk("rr_tail_count", 64'(g_cnt), 64'd2);
      req_valid = '0;
      tick();
      tick();

      // Backpressure: requester 2 waits with resp_ready low; other ready bits ignored.
      do_reset();
      resp_ready = 4'h0;
      req_valid  = 4'b0100;
      req_a[64 +: 32] = 32'h0020_0000;
      req_b[64 +: 32] = 32'h0060_0000;
      #1;
      chk("bp_grant", 64'(req_ready), 64'h4);
      tick();
      req_valid  = 4'b0001;
      resp_ready = 4'b1011;
      tick();
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_resp_valid", 64'(resp_valid), 64'h4);
         chk("bp_result", 64'(resp_result), 64'h0060_0000);
         chk("bp_req_ready", 64'(req_ready), 64'h0);
         chk("bp_busy", 64'(busy), 64'h1);
         tick();
      end
      resp_ready = 4'hF;
      #1;
      chk("bp_release_hold", 64'(resp_valid), 64'h4);
      tick();
      #1;
      chk("bp_idle_busy", 64'(busy), 64'h0);
      chk("bp_idle_resp_valid", 64'(resp_valid), 64'h0);
      chk("bp_next_grant", 64'(req_ready), 64'h1);
      req_valid = '0;
      tick();

      // Reset during MUL: rr_ptr was left at 2, so a surviving pointer would pick 3.
      resp_ready = 4'h0;
      req_valid  = 4'b0010;
      #1;
      chk("rm_grant", 64'(req_ready), 64'h2);
      tick();
      req_valid = 4'b1001;
      req_a[0 +: 32] = 32'h0020_0000;
      req_b[0 +: 32] = 32'h0060_0000;
      rst = 1'b1;
      tick();
      #1;
      chk_all_zero("rst_mul");
      rst = 1'b0;
      #1;
      chk("rst_mul_regrant", 64'(req_ready), 64'h1);

      // Reset during RESP with a non-zero held result.
      tick();
      req_valid = 4'b0101;
      tick();
      #1;
      chk("rr_resp_valid", 64'(resp_valid), 64'h1);
      chk("rr_resp_result", 64'(resp_result), 64'h0060_0000);
      rst = 1'b1;
      tick();
      #1;
      chk_all_zero("rst_resp");
      rst = 1'b0;
      #1;
      chk("rst_resp_regrant", 64'(req_ready), 64'h1);
      req_valid = '0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/mul_arbiter.md
# mul_arbiter

Shares one fixed-point `multiplier` instance (32-bit operands, format S + 10 integer + 21 fraction bits) among `NUM_REQ` requesters. Requests are granted round-robin with a valid/ready handshake, and operands are registered into the multiplier. The truncated product is returned on a shared response bus, tagged to the winning requester. It sits between the accelerator's compute units and the single multiplier, so that the datapath needs only one 32x32 multiply array.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`: bit i set means requester i presents operands.
- `req_a`  in  `NUM_REQ*32`: operand A, requester i on bits [32i+31:32i].
- `req_b`  in  `NUM_REQ*32`: operand B, same packing as `req_a`.
- `req_ready`  out  `NUM_REQ`: one-hot grant; transfer when `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  `NUM_REQ`: one-hot; bit i is set while the result for requester i is pending.
- `resp_ready`  in  `NUM_REQ`: requester i accepts its result.
- `resp_result`  out  32: truncated product, same fixed-point format as the operands.
- `resp_ovf`  out  1: product bits above the result window are non-zero.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, MUL, RESP.
- **IDLE**
  - Arbitrate among the set bits of `req_valid`, searching from `rr_ptr` upward with wrap (`rr_ptr`, `rr_ptr`+1, … mod `NUM_REQ`).
  - The first set bit i gets `req_ready[i]=1`, driven combinationally in the same cycle.
  - On that edge: latch `req_a`/`req_b` slice i into `op_a`/`op_b`, latch `id`=i, set `rr_ptr` = (i+1) mod `NUM_REQ`, and go to MUL.
  - If no bit of `req_valid` is set, stay in IDLE and leave `rr_ptr` unchanged.
- **MUL**
  - `op_a`/`op_b` drive the `multiplier` instance, which is unmodified and combinational.
  - On the edge: register `resp_result` = product[52:21] of the unsigned 32x32→64 product.
  - On the same edge: register `resp_ovf` = OR of product[63:53], then go to RESP.
  - No rounding and no saturation; the low 21 bits are discarded.
- **RESP**
  - `resp_valid[id]`=1. `resp_result` and `resp_ovf` are held stable.
  - When `resp_ready[id]`=1, go to IDLE on that edge.
  - `resp_ready` bits other than `id` are ignored.
- `req_ready` is all-zero outside IDLE. Requesters must hold `req_valid` and their operands until granted.
- Only one transaction is in flight at a time; there is no queuing.

## Timing
- Reset values: state IDLE, `rr_ptr`=0, `req_ready`=0, `resp_valid`=0, `resp_result`=0, `resp_ovf`=0, `busy`=0.
- Reset mid-operation: the in-flight transaction is dropped with no response issued. Outputs reach their reset values on the next edge.
- Latency: a request accepted at edge T produces `resp_valid` from T+2.
- With `resp_ready` held high, the next grant can occur in the cycle after T+2. Back-to-back throughput is therefore one operation per 3 cycles.
- Backpressure: `resp_valid` is held indefinitely while `resp_ready[id]` is low, and no grant is issued meanwhile.
- A new `req_valid` arriving during MUL or RESP waits for IDLE; its priority is set by `rr_ptr` at that time.
- If requester `id` raises `req_valid` in the same cycle it accepts its response, that request is arbitrated in the following IDLE cycle. It has the lowest priority among requesters that are valid in that cycle.
- `busy` is registered from the state (high in MUL and RESP).
- `req_ready` is the only combinational input-to-output path.

## Test plan
- **Single multiply.** Requester 0 sends a=0x00200000 (1.0), b=0x00600000 (3.0) at edge T. Required: `req_ready[0]` high in cycle T, `resp_valid[0]` high from T+2, `resp_result`=0x00600000, `resp_ovf`=0.
- **Fractional truncation.** Requester 1 sends a=b=0x00100000 (0.5 × 0.5). Required: `resp_result`=0x00080000. Then a=0x00000001, b=0x00000001. Required: `resp_result`=0x00000000, `resp_ovf`=0.
- **Overflow.** Requester 2 sends a=b=0x40000000 (512.0). Required: `resp_result`=0x00000000, `resp_ovf`=1.
- **Round-robin fairness.** All four `req_valid` held high and `resp_ready` all high. Required: grants occur in order 0,1,2,3,0,1, with grants 3 cycles apart. Then only requesters 1 and 3 are valid with `rr_ptr`=2. Required: grant order 3,1.
- **Backpressure.** Hold `resp_ready` low for 5 cycles in RESP. Required: `resp_valid` and `resp_result` are stable, `req_ready` stays 0, and `busy`=1. On release, return to IDLE on the next edge.
- **Reset mid-operation.** Assert `rst` in MUL, and separately in RESP. Required: on the next edge all outputs are 0, state is IDLE and `rr_ptr`=0. After `rst` deasserts, a pending request from requester 0 is granted in the first cycle.
